// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM register bank.
// Included by the top and the timebase.
package pwm_pkg;

    localparam int unsigned CLK_DIV_DEF  = 13;
    localparam int unsigned MAX_ADDR_DEF = 4;

    localparam logic [7:0] PWM_TOP = 8'd254;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_req_t;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaled 8-bit PWM counter (0..PWM_TOP) with period boundary
// strobe and a registered one-cycle sync pulse.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] pwm_cnt_o,
    output logic       boundary_o,
    output logic       sync_o
);

    logic [7:0] presc_q, presc_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sync_q, sync_d;
    logic       tick;

    always_comb begin
        tick       = (presc_q == 8'(CLK_DIV - 1));
        presc_d    = tick ? 8'd0 : presc_q + 8'd1;
        cnt_d      = cnt_q;
        if (tick) begin
            cnt_d = (cnt_q == PWM_TOP) ? 8'd0 : cnt_q + 8'd1;
        end
        // boundary is the edge that wraps the counter back to 0
        boundary_o = tick && (cnt_q == PWM_TOP);
        sync_d     = boundary_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= 8'd0;
            cnt_q   <= 8'd0;
            sync_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
        end
    end

    assign pwm_cnt_o = cnt_q;
    assign sync_o    = sync_q;

endmodule

// File: rtl/pwm_peripheral.sv
// Register bank with one-entry write hold buffer and 16-channel
// static/PWM output mux driven by the shared timebase.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
    parameter int unsigned MAX_ADDR = MAX_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [6:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [15:0] out,
    output logic        pwm_sync,
    output logic        wr_err
);

    logic        hold_vld_q, hold_vld_d;
    wr_req_t     hold_q, hold_d;
    logic [15:0] en_out_q, en_out_d;
    logic [15:0] en_pwm_q, en_pwm_d;
    logic [7:0]  duty_shadow_q, duty_shadow_d;
    logic [7:0]  duty_active_q, duty_active_d;
    logic [15:0] out_q, out_d;
    logic        wr_err_q, wr_err_d;
    logic [7:0]  pwm_cnt;
    logic        boundary;
    logic        level;

    pwm_timebase #(
        .CLK_DIV(CLK_DIV)
    ) u_timebase (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_cnt_o (pwm_cnt),
        .boundary_o(boundary),
        .sync_o    (pwm_sync)
    );

    always_comb begin
        hold_vld_d    = hold_vld_q;
        hold_d        = hold_q;
        en_out_d      = en_out_q;
        en_pwm_d      = en_pwm_q;
        duty_shadow_d = duty_shadow_q;
        wr_err_d      = 1'b0;
        // boundary samples the shadow value before any same-edge commit
        duty_active_d = boundary ? duty_shadow_q : duty_active_q;

        if (hold_vld_q) begin
            hold_vld_d = 1'b0;
            if (hold_q.addr > 7'(MAX_ADDR)) begin
                wr_err_d = 1'b1;
            end else begin
                unique case (1'b1)
                    hold_q.addr == ADDR_EN_OUT_LO: en_out_d[7:0]  = hold_q.data;
                    hold_q.addr == ADDR_EN_OUT_HI: en_out_d[15:8] = hold_q.data;
                    hold_q.addr == ADDR_EN_PWM_LO: en_pwm_d[7:0]  = hold_q.data;
                    hold_q.addr == ADDR_EN_PWM_HI: en_pwm_d[15:8] = hold_q.data;
                    hold_q.addr == ADDR_DUTY:      duty_shadow_d  = hold_q.data;
                    default: ;
                endcase
            end
        end else if (wr_valid) begin
            hold_vld_d = 1'b1;
            hold_d     = '{addr: wr_addr, data: wr_data};
        end

        level = (duty_active_q == 8'hFF) || (pwm_cnt < duty_active_q);
        out_d = en_out_q & (~en_pwm_q | {16{level}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q    <= 1'b0;
            hold_q        <= '0;
            en_out_q      <= '0;
            en_pwm_q      <= '0;
            duty_shadow_q <= '0;
            duty_active_q <= '0;
            out_q         <= '0;
            wr_err_q      <= 1'b0;
        end else begin
            hold_vld_q    <= hold_vld_d;
            hold_q        <= hold_d;
            en_out_q      <= en_out_d;
            en_pwm_q      <= en_pwm_d;
            duty_shadow_q <= duty_shadow_d;
            duty_active_q <= duty_active_d;
            out_q         <= out_d;
            wr_err_q      <= wr_err_d;
        end
    end

    assign wr_ready = !hold_vld_q;
    assign out      = out_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomized bench for pwm_peripheral against a cycle-step
// reference model whose timebase is pure edge-count arithmetic.
module tb_pwm_peripheral;

    localparam int unsigned CLK_DIV = 13;
    localparam int unsigned P       = 255 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] pwm_out;
    logic        pwm_sync;
    logic        wr_err;

    int n_chk  = 0;
    int n_fail = 0;

    // model state: n = edges since reset release
    int unsigned n;
    logic [15:0] m_en_out, m_en_pwm;
    logic [7:0]  m_sh, m_act;
    logic        m_pend;
    logic [6:0]  m_addr;
    logic [7:0]  m_data;
    int unsigned last_acc;

    pwm_peripheral #(
        .CLK_DIV (CLK_DIV),
        .MAX_ADDR(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .out     (pwm_out),
        .pwm_sync(pwm_sync),
        .wr_err  (wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at n=%0d",
                     tag, act, exp, n);
        end
    endtask

    task automatic model_reset();
        n        = 0;
        m_en_out = '0;
        m_en_pwm = '0;
        m_sh     = '0;
        m_act    = '0;
        m_pend   = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endtask

    // advance one edge, predicting every output from spec rules
    task automatic step();
        int unsigned cnt;
        logic        lvl, bnd, err;
        logic [15:0] eo;
        logic [7:0]  sh_old;
        cnt    = (n / CLK_DIV) % 255;
        lvl    = (m_act == 8'hFF) || (cnt < m_act);
        eo     = m_en_out & (~m_en_pwm | {16{lvl}});
        bnd    = ((n + 1) % P) == 0;
        sh_old = m_sh;
        err    = 1'b0;
        if (m_pend) begin
            m_pend = 1'b0;
            if (m_addr > 7'd4) err = 1'b1;
            else begin
                case (m_addr)
                    7'd0: m_en_out[7:0]  = m_data;
                    7'd1: m_en_out[15:8] = m_data;
                    7'd2: m_en_pwm[7:0]  = m_data;
                    7'd3: m_en_pwm[15:8] = m_data;
                    default: m_sh = m_data;
                endcase
            end
        end else if (wr_valid) begin
            m_pend = 1'b1;
            m_addr = wr_addr;
            m_data = wr_data;
        end
        if (bnd) m_act = sh_old;
        n++;
        @(posedge clk);
        #1;
        chk("cyc", {13'd0, pwm_out, pwm_sync, wr_err, wr_ready},
            {13'd0, eo, bnd, err, !m_pend});
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        logic rdy;
        int   k;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        k = 0;
        rdy = 1'b0;
        while (!rdy && k < 16) begin
            rdy = wr_ready;
            step();
            k++;
        end
        if (!rdy) chk("wr_timeout", 32'd0, 32'd1);
        last_acc = n;
        wr_valid = 1'b0;
    endtask

    task automatic wait_sync();
        int k;
        k = 0;
        while (pwm_sync !== 1'b1 && k < 2 * P + 4) begin
            step();
            k++;
        end
        if (pwm_sync !== 1'b1) chk("sync_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_hi(output int c);
        c = 0;
        for (int i = 0; i < P; i++) begin
            step();
            c += int'(pwm_out[0]);
        end
    endtask

    int          hi;
    int unsigned acc1;

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {13'd0, pwm_out, pwm_sync, wr_err, wr_ready},
            {13'd0, 16'h0000, 1'b0, 1'b0, 1'b1});
        rst_n = 1'b1;

        // static enable, back-to-back with valid held high
        wr(7'h00, 8'hFF);
        acc1 = last_acc;
        wr(7'h01, 8'h0F);
        chk("b2b_gap", last_acc - acc1, 32'd2);
        step();
        step();
        chk("static_out", {16'd0, pwm_out}, 32'h0FFF);
        repeat (20) step();

        // 50% on channel 0 only
        wr(7'h00, 8'h01);
        wr(7'h01, 8'h00);
        wr(7'h02, 8'h01);
        wr(7'h04, 8'h80);
        wait_sync();
        count_hi(hi);
        chk("duty80_hi", hi, 128 * CLK_DIV);

        wr(7'h04, 8'h00);
        wait_sync();
        count_hi(hi);
        chk("duty00_hi", hi, 0);

        wr(7'h04, 8'hFF);
        wait_sync();
        count_hi(hi);
        chk("dutyFF_hi", hi, P);

        // duty commit landing on the boundary edge itself
        wr(7'h04, 8'h80);
        wait_sync();
        while (((n + 2) % P) != 0) step();
        wr(7'h04, 8'h40);
        step();
        chk("bnd_sync", {31'd0, pwm_sync}, 32'd1);
        count_hi(hi);
        chk("bnd_old_hi", hi, 128 * CLK_DIV);
        count_hi(hi);
        chk("bnd_new_hi", hi, 64 * CLK_DIV);

        // illegal address
        wr(7'h05, 8'hAA);
        step();
        chk("ill_err", {30'd0, wr_err, wr_ready}, 32'd3);
        step();
        chk("ill_err_off", {31'd0, wr_err}, 32'd0);
        chk("ill_regs", {16'd0, m_en_out}, 32'h0001);

        // random traffic, valid regardless of ready
        for (int i = 0; i < 3 * P; i++) begin
            wr_valid = 1'($urandom);
            wr_addr  = ($urandom_range(0, 15) == 0) ? 7'h7F
                                                    : 7'($urandom_range(0, 6));
            wr_data  = 8'($urandom);
            step();
        end

        // asynchronous reset mid-operation
        wr_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {13'd0, pwm_out, pwm_sync, wr_err, wr_ready},
            {13'd0, 16'h0000, 1'b0, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        wait_sync();
        chk("first_sync", n, P);
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
